// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, no-write-allocate MEM-stage data cache; hit/flush done 2 cycles after en.
// Requests outside IDLE are ignored; define DCACHE_STATS_EN to add hit/miss counters.
module dcache #(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dcache_en,
    input  logic        dcache_wren,
    input  logic        dcache_flush,
    input  logic [63:0] dcache_addr,
    input  logic [63:0] dcache_wdata,
    output logic [63:0] dcache_rdata,
    output logic        dcache_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 61 - OFF_W - IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, FILL, WRITE, DONE} state_t;

    state_t           state_q;
    logic [60:0]      waddr_q;
    logic [63:0]      wdata_q;
    logic [63:0]      fill_word_q;
    logic             wr_q;
    logic             flush_q;
    logic [OFF_W-1:0] beat_q;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [63:0]      data_q [LINES*LINE_WORDS];
    logic             done_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [63:0]      mem_addr_q;
    logic [63:0]      mem_wdata_q;
    logic [63:0]      rdata_q;
`ifdef DCACHE_STATS_EN
    logic [31:0]      hits_q;
    logic [31:0]      misses_q;
`endif

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             last_beat;
    logic             unused_addr_bits;

    assign off              = waddr_q[OFF_W-1:0];
    assign idx              = waddr_q[OFF_W +: IDX_W];
    assign tag              = waddr_q[60:OFF_W+IDX_W];
    assign hit              = valid_q[idx] && (tag_q[idx] == tag);
    assign last_beat        = (beat_q == OFF_W'(LINE_WORDS - 1));
    assign unused_addr_bits = ^dcache_addr[2:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            fill_word_q <= '0;
            wr_q        <= 1'b0;
            flush_q     <= 1'b0;
            beat_q      <= '0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
`ifdef DCACHE_STATS_EN
            hits_q      <= '0;
            misses_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dcache_en) begin
                        waddr_q <= dcache_addr[63:3];
                        wdata_q <= dcache_wdata;
                        flush_q <= dcache_flush;
                        wr_q    <= dcache_wren & ~dcache_flush;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
`ifdef DCACHE_STATS_EN
                    if (!flush_q) begin
                        if (hit) hits_q   <= hits_q + 32'd1;
                        else     misses_q <= misses_q + 32'd1;
                    end
`endif
                    if (flush_q) begin
                        if (hit) valid_q[idx] <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (wr_q) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {waddr_q, 3'b000};
                        mem_wdata_q <= wdata_q;
                        state_q     <= WRITE;
                    end else if (hit) begin
                        rdata_q <= data_q[{idx, off}];
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        // Line is about to be overwritten beat by beat; keep it invalid until the fill completes.
                        valid_q[idx] <= 1'b0;
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= {waddr_q[60:OFF_W], {(OFF_W+3){1'b0}}};
                        state_q      <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    if (mem_rvalid) begin
                        beat_q <= beat_q + OFF_W'(1);
                        if (beat_q == off) fill_word_q <= mem_rdata;
                        if (last_beat) begin
                            valid_q[idx] <= 1'b1;
                            rdata_q      <= (beat_q == off) ? mem_rdata : fill_word_q;
                            done_q       <= 1'b1;
                            state_q      <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data and tag arrays carry no reset; validity alone decides whether they are used.
    always_ff @(posedge clk) begin
        if (!reset && state_q == LOOKUP && wr_q && hit) begin
            data_q[{idx, off}] <= wdata_q;
        end
        if (!reset && state_q == FILL && mem_rvalid) begin
            data_q[{idx, beat_q}] <= mem_rdata;
            if (last_beat) tag_q[idx] <= tag;
        end
    end

    assign dcache_rdata = rdata_q;
    assign dcache_done  = done_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
`ifdef DCACHE_STATS_EN
    assign stat_hits    = hits_q;
    assign stat_misses  = misses_q;
`endif
endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: a task-driven memory responder plus per-scenario inline checks.
module tb_dcache;
    logic        clk = 1'b0;
    logic        reset;
    logic        dcache_en, dcache_wren, dcache_flush;
    logic [63:0] dcache_addr, dcache_wdata, dcache_rdata;
    logic        dcache_done;
    logic        mem_req, mem_we, mem_ack, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    int total = 0;
    int bad   = 0;
    logic [63:0] model [logic [63:0]];

    localparam int OP_RD = 0, OP_WR = 1, OP_FL = 2;

    dcache dut (
        .clk(clk), .reset(reset),
        .dcache_en(dcache_en), .dcache_wren(dcache_wren), .dcache_flush(dcache_flush),
        .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_done(dcache_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (model.exists(a)) return model[a];
        return ((a >> 4) & ~64'h7) | ((a >> 3) & 64'h7);
    endfunction

    // Issues one request at a negedge and plays memory until done or budget expiry.
    task automatic run_req(input int op, input logic [63:0] a, input logic [63:0] wd,
                           input int gap, input int abort_beat, input int budget,
                           output int done_k, output logic [63:0] rd, output logic done2,
                           output logic req_seen, output logic req_we,
                           output logic [63:0] req_addr, output logic [63:0] req_wd);
        logic        acked, filling;
        int          beats, start;
        logic [63:0] fbase;
        done_k = -1; rd = '0; done2 = 1'b0;
        req_seen = 1'b0; req_we = 1'b0; req_addr = '0; req_wd = '0;
        acked = 1'b0; filling = 1'b0; beats = 0; start = 0; fbase = '0;
        dcache_en    = 1'b1;
        dcache_wren  = (op == OP_WR);
        dcache_flush = (op == OP_FL);
        dcache_addr  = a;
        dcache_wdata = wd;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            dcache_en = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0; reset = 1'b0;
            if (dcache_done) begin
                done_k = k;
                rd     = dcache_rdata;
                @(negedge clk);
                done2 = dcache_done;
                break;
            end
            if (mem_req && !acked) begin
                req_seen = 1'b1; req_we = mem_we; req_addr = mem_addr; req_wd = mem_wdata;
                mem_ack = 1'b1;
                acked   = 1'b1;
                if (mem_we) model[mem_addr] = mem_wdata;
                else begin
                    filling = 1'b1;
                    start   = k + 1;
                    fbase   = mem_addr;
                end
            end else if (filling && beats < 8 && k >= start && ((k - start) % (gap + 1)) == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(fbase + 64'(beats << 3));
                beats++;
                if (beats == abort_beat) reset = 1'b1;
            end
        end
        mem_ack = 1'b0; mem_rvalid = 1'b0; reset = 1'b0; dcache_en = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (dcache_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", dcache_done); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        total++; if (mem_addr !== 64'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        total++; if (mem_wdata !== 64'h0) begin bad++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        total++; if (dcache_rdata !== 64'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", dcache_rdata); end
`ifdef DCACHE_STATS_EN
        total++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin bad++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_hits, stat_misses); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_cold_read;
        int k; logic [63:0] rd, ra, rw; logic d2, rs, we;
        run_req(OP_RD, 64'h1000, 64'h0, 0, -1, 40, k, rd, d2, rs, we, ra, rw);
        total++; if (!(rs === 1'b1 && we === 1'b0 && ra === 64'h1000)) begin bad++; $display("FAIL cold_fill_req: got req=%b we=%b addr=%h want 1 0 1000", rs, we, ra); end
        total++; if (k !== 11) begin bad++; $display("FAIL cold_done_cycle: got %0d want 11", k); end
        total++; if (rd !== 64'h100) begin bad++; $display("FAIL cold_rdata: got %h want 100", rd); end
        total++; if (d2 !== 1'b0) begin bad++; $display("FAIL cold_done_width: got %b want 0", d2); end
    endtask

    task automatic test_read_hit;
        int k; logic [63:0] rd, ra, rw; logic d2, rs, we;
        run_req(OP_RD, 64'h1018, 64'h0, 0, -1, 20, k, rd, d2, rs, we, ra, rw);
        total++; if (rs !== 1'b0) begin bad++; $display("FAIL hit_no_req: got %b want 0", rs); end
        total++; if (k !== 2) begin bad++; $display("FAIL hit_done_cycle: got %0d want 2", k); end
        total++; if (rd !== 64'h103) begin bad++; $display("FAIL hit_rdata: got %h want 103", rd); end
        total++; if (d2 !== 1'b0) begin bad++; $display("FAIL hit_done_width: got %b want 0", d2); end
    endtask

    task automatic test_write_hit;
        int k; logic [63:0] rd, ra, rw; logic d2, rs, we;
        run_req(OP_WR, 64'h1008, 64'hDEAD, 0, -1, 20, k, rd, d2, rs, we, ra, rw);
        total++; if (!(rs === 1'b1 && we === 1'b1 && ra === 64'h1008 && rw === 64'hDEAD)) begin bad++; $display("FAIL wr_hit_mem: got req=%b we=%b addr=%h data=%h want 1 1 1008 dead", rs, we, ra, rw); end
        total++; if (k !== 3) begin bad++; $display("FAIL wr_hit_done_cycle: got %0d want 3", k); end
        run_req(OP_RD, 64'h1008, 64'h0, 0, -1, 20, k, rd, d2, rs, we, ra, rw);
        total++; if (rs !== 1'b0 || k !== 2) begin bad++; $display("FAIL wr_hit_reread: got req=%b done=%0d want 0 2", rs, k); end
        total++; if (rd !== 64'hDEAD) begin bad++; $display("FAIL wr_hit_rdata: got %h want dead", rd); end
    endtask

    task automatic test_flush;
        int k; logic [63:0] rd, ra, rw; logic d2, rs, we;
        run_req(OP_FL, 64'h1000, 64'h0, 0, -1, 20, k, rd, d2, rs, we, ra, rw);
        total++; if (rs !== 1'b0 || k !== 2) begin bad++; $display("FAIL flush_done: got req=%b done=%0d want 0 2", rs, k); end
        run_req(OP_RD, 64'h1000, 64'h0, 1, -1, 40, k, rd, d2, rs, we, ra, rw);
        total++; if (!(rs === 1'b1 && we === 1'b0 && ra === 64'h1000)) begin bad++; $display("FAIL flush_refill_req: got req=%b we=%b addr=%h want 1 0 1000", rs, we, ra); end
        total++; if (k !== 18) begin bad++; $display("FAIL gap_fill_done_cycle: got %0d want 18", k); end
        total++; if (rd !== 64'h100) begin bad++; $display("FAIL flush_refill_rdata: got %h want 100", rd); end
        run_req(OP_RD, 64'h1008, 64'h0, 0, -1, 20, k, rd, d2, rs, we, ra, rw);
        total++; if (rs !== 1'b0 || rd !== 64'hDEAD) begin bad++; $display("FAIL refill_written_word: got req=%b data=%h want 0 dead", rs, rd); end
        run_req(OP_FL, 64'h5000, 64'h0, 0, -1, 20, k, rd, d2, rs, we, ra, rw);
        total++; if (rs !== 1'b0 || k !== 2) begin bad++; $display("FAIL flush_miss_done: got req=%b done=%0d want 0 2", rs, k); end
        run_req(OP_RD, 64'h1010, 64'h0, 0, -1, 20, k, rd, d2, rs, we, ra, rw);
        total++; if (rs !== 1'b0 || rd !== 64'h102) begin bad++; $display("FAIL flush_other_tag_kept: got req=%b data=%h want 0 102", rs, rd); end
    endtask

    task automatic test_back_to_back;
        int k; logic [63:0] rd, ra, rw; logic d2, rs, we;
        run_req(OP_RD, 64'h1038, 64'h0, 0, -1, 20, k, rd, d2, rs, we, ra, rw);
        total++; if (k !== 2 || rd !== 64'h107) begin bad++; $display("FAIL b2b_first: got done=%0d data=%h want 2 107", k, rd); end
        run_req(OP_RD, 64'h2038, 64'h0, 0, -1, 40, k, rd, d2, rs, we, ra, rw);
        total++; if (!(rs === 1'b1 && ra === 64'h2000 && k === 11)) begin bad++; $display("FAIL b2b_miss: got req=%b addr=%h done=%0d want 1 2000 11", rs, ra, k); end
        total++; if (rd !== 64'h207) begin bad++; $display("FAIL last_word_rdata: got %h want 207", rd); end
        run_req(OP_RD, 64'h2030, 64'h0, 0, -1, 20, k, rd, d2, rs, we, ra, rw);
        total++; if (rs !== 1'b0 || k !== 2 || rd !== 64'h206) begin bad++; $display("FAIL b2b_hit: got req=%b done=%0d data=%h want 0 2 206", rs, k, rd); end
`ifdef DCACHE_STATS_EN
        total++; if (stat_hits !== 32'd7 || stat_misses !== 32'd3) begin bad++; $display("FAIL stats_count: got %0d/%0d want 7/3", stat_hits, stat_misses); end
`endif
    endtask

    task automatic test_write_miss;
        int k; logic [63:0] rd, ra, rw; logic d2, rs, we;
        run_req(OP_WR, 64'h9000, 64'hBEEF, 0, -1, 20, k, rd, d2, rs, we, ra, rw);
        total++; if (!(rs === 1'b1 && we === 1'b1 && ra === 64'h9000 && rw === 64'hBEEF && k === 3)) begin bad++; $display("FAIL wr_miss_mem: got req=%b we=%b addr=%h data=%h done=%0d want 1 1 9000 beef 3", rs, we, ra, rw, k); end
        run_req(OP_RD, 64'h9000, 64'h0, 0, -1, 40, k, rd, d2, rs, we, ra, rw);
        total++; if (!(rs === 1'b1 && we === 1'b0 && ra === 64'h9000)) begin bad++; $display("FAIL wr_miss_no_alloc: got req=%b we=%b addr=%h want 1 0 9000", rs, we, ra); end
        total++; if (rd !== 64'hBEEF) begin bad++; $display("FAIL wr_miss_readback: got %h want beef", rd); end
    endtask

    task automatic test_reset_abort;
        int k; logic [63:0] rd, ra, rw; logic d2, rs, we;
        run_req(OP_RD, 64'h3000, 64'h0, 0, 4, 20, k, rd, d2, rs, we, ra, rw);
        total++; if (k !== -1) begin bad++; $display("FAIL abort_no_done: got done=%0d want -1", k); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL abort_mem_req: got %b want 0", mem_req); end
`ifdef DCACHE_STATS_EN
        total++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin bad++; $display("FAIL abort_stats: got %0d/%0d want 0/0", stat_hits, stat_misses); end
`endif
        run_req(OP_RD, 64'h3000, 64'h0, 0, -1, 40, k, rd, d2, rs, we, ra, rw);
        total++; if (!(rs === 1'b1 && ra === 64'h3000 && k === 11)) begin bad++; $display("FAIL abort_refill: got req=%b addr=%h done=%0d want 1 3000 11", rs, ra, k); end
        total++; if (rd !== 64'h300) begin bad++; $display("FAIL abort_refill_rdata: got %h want 300", rd); end
    endtask

    initial begin
        reset = 1'b1; dcache_en = 1'b0; dcache_wren = 1'b0; dcache_flush = 1'b0;
        dcache_addr = '0; dcache_wdata = '0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_hit();
        test_flush();
        test_back_to_back();
        test_write_miss();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
